fft_sample_loader: RTL
======================

FFT_SAMPLE_LOADER -- requirements
Module: fft_sample_loader

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning packed sample width ({re[31:16], im[15:0]}).
REQ-002 SHALL have parameter ADDR_W, default 12, meaning sample RAM address width.
REQ-003 SHALL have parameter BITREV, default 1, meaning 1 = write at bit-reversed address, 0 = natural order.
REQ-004 SHALL have port clk  in  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port nrst  in  1  reset, asynchronous assertion, active-low.
REQ-006 SHALL have port ce  in  1  clock enable; when 0 all state and outputs hold.
REQ-007 SHALL have port sample_num  in  ADDR_W  frame length N, sampled at start.
REQ-008 SHALL have port start  in  1  single-cycle request to load one frame.
REQ-009 SHALL have port load_nCompute  in  1  from controller FSM; 1 = loader owns sample RAM, 0 = compute phase.
REQ-010 SHALL have port s_valid  in  1  input sample valid.
REQ-011 SHALL have port s_data  in  DATA_W  input sample.
REQ-012 SHALL have port s_ready  out  1  loader accepts sample this cycle.
REQ-013 SHALL have port wr_en  out  1  sample RAM write strobe.
REQ-014 SHALL have port wr_adr  out  ADDR_W  sample RAM write address.
REQ-015 SHALL have port wr_data  out  DATA_W  sample RAM write data.
REQ-016 SHALL have port data_loaded  out  1  frame complete, level until controller leaves load phase.
REQ-017 SHALL have port cfg_err  out  1  one-cycle pulse: start rejected (bad sample_num).

Function
REQ-018 SHALL implement states IDLE, LOAD, DONE, COMPUTE_WAIT.
REQ-019 IDLE: on ce & start & load_nCompute & N valid -> LOAD; latch N, k = log2(N), clear sample counter.
REQ-020 N valid SHALL mean power of two in 2..2^(ADDR_W-1); otherwise stay IDLE and pulse cfg_err for one cycle.
REQ-021 start SHALL be ignored in LOAD, DONE, COMPUTE_WAIT, and in IDLE while load_nCompute = 0.
REQ-022 s_ready SHALL be combinational: 1 only in LOAD with ce = 1 and load_nCompute = 1.
REQ-023 A transfer SHALL occur when s_valid & s_ready; s_data held by source until transfer.
REQ-024 wr_en, wr_adr, wr_data SHALL be registered: asserted exactly one cycle after each transfer, wr_en = 0 otherwise.
REQ-025 wr_adr SHALL be count (BITREV = 0) or count with its low k bits reversed and upper bits zero (BITREV = 1); count = 0..N-1.
REQ-026 On transfer of sample N-1: LOAD -> DONE; data_loaded SHALL rise in the same cycle as the final wr_en.
REQ-027 DONE: data_loaded = 1; on load_nCompute = 0 -> COMPUTE_WAIT, data_loaded = 0 next cycle.
REQ-028 COMPUTE_WAIT: s_ready = 0; on load_nCompute = 1 -> IDLE.
REQ-029 load_nCompute falling during LOAD SHALL abort: -> IDLE, no further writes, data_loaded stays 0.
REQ-030 Counter SHALL never exceed N-1; no wrap-around writes.
REQ-031 ce = 0 in any cycle SHALL suppress transfer, writes and transitions (wr_en forced 0 that cycle).

Reset
REQ-032 nrst = 0 SHALL asynchronously force state IDLE, counter 0, N 0, wr_en 0, wr_adr 0, wr_data 0, data_loaded 0, cfg_err 0.
REQ-033 Reset mid-LOAD SHALL discard the partial frame; no write after reset release until new start.

Structure
REQ-034 fft_pkg SHALL hold the loader state enum typedef, DATA_W/ADDR_W defaults and the packed sample typedef.
REQ-035 Bit reversal SHALL be sub-module fft_bit_reverse (inputs: value, k; output: reversed address), combinational.

Verification
REQ-036 N=8, BITREV=1, continuous s_valid with data 0..7 -> wr_adr 0,4,2,6,1,5,3,7 with wr_data 0..7; data_loaded rises with last wr_en.
REQ-037 N=16, BITREV=0, s_valid toggled every other cycle -> 16 writes, wr_adr 0..15 in order, no duplicates/gaps.
REQ-038 sample_num=12 with start -> cfg_err pulses one cycle, state IDLE, s_ready 0, no wr_en.
REQ-039 N=8, load_nCompute dropped after 3 transfers -> exactly 3 writes, data_loaded never 1, return to IDLE.
REQ-040 DONE, load_nCompute 1->0->1 -> data_loaded clears one cycle after fall; second start accepted only after return to 1.
REQ-041 nrst pulsed asynchronously mid-LOAD, plus ce = 0 for 5 cycles mid-frame -> outputs reset immediately; ce gap yields no transfers and frame completes correctly afterwards.

Source files
------------

// File: rtl/fft_pkg.sv
// ---------------------------------------------------------------------------
// fft_pkg
// Shared types and defaults for the FFT sample loader.
//   loader_state_t : loader FSM state encoding
//   sample_t       : packed complex sample {re[31:16], im[15:0]}
//   DATA_W_DEF / ADDR_W_DEF : default sample width and RAM address width
// ---------------------------------------------------------------------------
package fft_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int ADDR_W_DEF = 12;

   typedef enum logic [1:0] {
      ST_IDLE         = 2'd0,
      ST_LOAD         = 2'd1,
      ST_DONE         = 2'd2,
      ST_COMPUTE_WAIT = 2'd3
   } loader_state_t;

   typedef struct packed {
      logic [15:0] re;
      logic [15:0] im;
   } sample_t;

endpackage

// File: rtl/fft_bit_reverse.sv
// ---------------------------------------------------------------------------
// fft_bit_reverse
// Combinational bit reversal of the low k bits of an address; upper bits
// of the result are zero.
//   value    : in  ADDR_W  address to reverse (expected < 2^k)
//   k        : in  KW      number of low bits to reverse
//   reversed : out ADDR_W  low k bits of value in reversed order
// ---------------------------------------------------------------------------
module fft_bit_reverse #(
   parameter int  ADDR_W = 12,
   localparam int KW     = $clog2(ADDR_W + 1)
) (
   input  logic [ADDR_W-1:0] value,
   input  logic [KW-1:0]     k,
   output logic [ADDR_W-1:0] reversed
);

   logic [ADDR_W-1:0] mirrored;
   logic [KW-1:0]     shamt;

   // Mirror the full word, then shift the reversed field down so only the
   // low k bits of value land in the result; anything above bit k-1 of
   // value falls off the bottom.
   always_comb begin
      mirrored = '0;
      for (int i = 0; i < ADDR_W; i++) begin
         mirrored[i] = value[ADDR_W-1-i];
      end
   end

   assign shamt    = KW'(ADDR_W) - k;
   assign reversed = mirrored >> shamt;

endmodule

// File: rtl/fft_sample_loader.sv
// ---------------------------------------------------------------------------
// fft_sample_loader
// Loads one frame of N samples from a valid/ready stream into the FFT
// sample RAM, optionally at bit-reversed addresses.
//   clk           : in  sole clock, rising edge
//   nrst          : in  async active-low reset
//   ce            : in  clock enable; 0 holds all state
//   sample_num    : in  frame length N, captured on accepted start
//   start         : in  single-cycle frame load request
//   load_nCompute : in  1 = loader owns sample RAM, 0 = compute phase
//   s_valid       : in  input sample valid
//   s_data        : in  input sample
//   s_ready       : out loader accepts a sample this cycle (combinational)
//   wr_en         : out sample RAM write strobe (registered)
//   wr_adr        : out sample RAM write address (registered)
//   wr_data       : out sample RAM write data (registered)
//   data_loaded   : out frame complete, held until load phase ends
//   cfg_err       : out one-cycle pulse: start rejected, bad sample_num
//
// state           | meaning
// ----------------+-----------------------------------------------------
// ST_IDLE         | waiting for start with a valid N
// ST_LOAD         | accepting samples, writing RAM
// ST_DONE         | frame complete, data_loaded high
// ST_COMPUTE_WAIT | compute phase running, waiting for load phase again
// ---------------------------------------------------------------------------
module fft_sample_loader
   import fft_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter bit BITREV = 1'b1
) (
   input  logic              clk,
   input  logic              nrst,
   input  logic              ce,
   input  logic [ADDR_W-1:0] sample_num,
   input  logic              start,
   input  logic              load_nCompute,
   input  logic              s_valid,
   input  logic [DATA_W-1:0] s_data,
   output logic              s_ready,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_adr,
   output logic [DATA_W-1:0] wr_data,
   output logic              data_loaded,
   output logic              cfg_err
);

   localparam int KW = $clog2(ADDR_W + 1);

   loader_state_t     state;
   loader_state_t     state_nxt;
   logic [ADDR_W-1:0] n_reg;
   logic [ADDR_W-1:0] count;
   logic [ADDR_W-1:0] rev_adr;
   logic [KW-1:0]     k_reg;
   logic [KW-1:0]     n_log2;
   logic              n_ok;
   logic              start_req;
   logic              start_go;
   logic              start_bad;
   logic              xfer;
   logic              last;
   logic              leave_done;

   // Power of two, at least 2; the top of the range is implied by the width.
   assign n_ok = (sample_num != '0) && !sample_num[0] &&
                 ((sample_num & (sample_num - ADDR_W'(1))) == '0);

   always_comb begin
      n_log2 = '0;
      for (int i = 0; i < ADDR_W; i++) begin
         if (sample_num[i]) n_log2 = KW'(i);
      end
   end

   assign start_req = ce & start & load_nCompute;
   assign last      = (count == (n_reg - ADDR_W'(1)));

   always_comb begin
      state_nxt  = state;
      s_ready    = 1'b0;
      xfer       = 1'b0;
      start_go   = 1'b0;
      start_bad  = 1'b0;
      leave_done = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start_req) begin
               if (n_ok) begin
                  start_go  = 1'b1;
                  state_nxt = ST_LOAD;
               end else begin
                  start_bad = 1'b1;
               end
            end
         end
         ST_LOAD: begin
            if (ce) begin
               if (!load_nCompute) begin
                  state_nxt = ST_IDLE;
               end else begin
                  s_ready = 1'b1;
                  if (s_valid) begin
                     xfer = 1'b1;
                     if (last) state_nxt = ST_DONE;
                  end
               end
            end
         end
         ST_DONE: begin
            if (ce && !load_nCompute) begin
               leave_done = 1'b1;
               state_nxt  = ST_COMPUTE_WAIT;
            end
         end
         ST_COMPUTE_WAIT: begin
            if (ce && load_nCompute) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   fft_bit_reverse #(.ADDR_W(ADDR_W)) u_bit_reverse (
      .value    (count),
      .k        (k_reg),
      .reversed (rev_adr)
   );

   // xfer and start_bad already require ce, so the strobes drop to zero in
   // any ce=0 cycle instead of repeating a write.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         n_reg       <= '0;
         k_reg       <= '0;
         count       <= '0;
         wr_en       <= 1'b0;
         wr_adr      <= '0;
         wr_data     <= '0;
         data_loaded <= 1'b0;
         cfg_err     <= 1'b0;
      end else begin
         wr_en   <= xfer;
         cfg_err <= start_bad;
         if (start_go) begin
            n_reg <= sample_num;
            k_reg <= n_log2;
            count <= '0;
         end
         if (xfer) begin
            wr_adr  <= BITREV ? rev_adr : count;
            wr_data <= s_data;
            if (!last) count <= count + ADDR_W'(1);
         end
         if (xfer && last)    data_loaded <= 1'b1;
         else if (leave_done) data_loaded <= 1'b0;
      end
   end

endmodule
